// File: rtl/bnn_seq_stream.sv
// Sequential binarized neural network engine: one hidden layer of sign neurons
// evaluated PAR at a time, then one popcount class per cycle, with valid/ready handshakes.
module bnn_seq_stream #(
   parameter int unsigned FEAT_CNT   = 12,
   parameter int unsigned FEAT_BITS  = 4,
   parameter int unsigned HIDDEN_CNT = 40,
   parameter int unsigned CLASS_CNT  = 6,
   parameter int unsigned PAR        = 8,
   parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  Weights0 = '0,
   parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] Weights1 = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [FEAT_CNT*FEAT_BITS-1:0]     features,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(CLASS_CNT)-1:0]      prediction,
   output logic [$clog2(HIDDEN_CNT+1)-1:0]   score
);

   localparam int unsigned GRP_CNT = (HIDDEN_CNT + PAR - 1) / PAR;
   localparam int unsigned GRP_W   = (GRP_CNT > 1) ? $clog2(GRP_CNT) : 1;
   localparam int unsigned CLS_W   = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
   localparam int unsigned PRED_W  = $clog2(CLASS_CNT);
   localparam int unsigned SCORE_W = $clog2(HIDDEN_CNT + 1);
   localparam int unsigned ACC_W   = $clog2(FEAT_CNT * (2**FEAT_BITS - 1) + 1) + 1;
   localparam int unsigned HID_IW  = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
   localparam int unsigned W0_IW   = $clog2(HIDDEN_CNT * FEAT_CNT);
   localparam int unsigned W1_IW   = $clog2(CLASS_CNT * HIDDEN_CNT);

   typedef enum logic [1:0] {S_IDLE, S_HID, S_CLS, S_OUT} state_t;

   state_t                          state_q, state_nxt;
   logic [FEAT_CNT*FEAT_BITS-1:0]   feat_q;
   logic [HIDDEN_CNT-1:0]           hid_q;
   logic [GRP_W-1:0]                grp_q;
   logic [CLS_W-1:0]                cls_q;
   logic [PRED_W-1:0]               best_idx_q;
   logic [SCORE_W-1:0]              best_score_q;

   logic [PAR-1:0]                  lane_hid_c;
   logic [PAR-1:0]                  lane_ok_c;
   logic [HID_IW-1:0]               lane_idx_c [PAR];
   logic [HIDDEN_CNT-1:0]           w1_row_c;
   logic [SCORE_W-1:0]              cls_score_c;
   logic                            better_c;

   // Next-state selection
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_nxt = S_HID;
         S_HID:   if (grp_q == GRP_W'(GRP_CNT - 1)) state_nxt = S_CLS;
         S_CLS:   if (cls_q == CLS_W'(CLASS_CNT - 1)) state_nxt = S_OUT;
         S_OUT:   if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Hidden-neuron lanes of the current group; lanes past the last neuron are masked
   always_comb begin
      int                     h;
      logic [FEAT_CNT-1:0]    w0_row;
      logic signed [ACC_W-1:0] acc;
      logic signed [ACC_W-1:0] x;
      h      = 0;
      w0_row = '0;
      acc    = '0;
      x      = '0;
      lane_hid_c = '0;
      lane_ok_c  = '0;
      for (int l = 0; l < PAR; l++) begin
         h = int'(grp_q) * int'(PAR) + l;
         lane_ok_c[l] = (h < int'(HIDDEN_CNT));
         if (!lane_ok_c[l]) h = 0;
         lane_idx_c[l] = HID_IW'(h);
         w0_row = Weights0[W0_IW'(h * int'(FEAT_CNT)) +: FEAT_CNT];
         acc = '0;
         for (int f = 0; f < FEAT_CNT; f++) begin
            x = ACC_W'(feat_q[f*FEAT_BITS +: FEAT_BITS]);
            if (w0_row[f]) acc = acc + x;
            else           acc = acc - x;
         end
         lane_hid_c[l] = ~acc[ACC_W-1];
      end
   end

   // XNOR-popcount score of the current class against the running best
   always_comb begin
      logic m;
      m = 1'b0;
      w1_row_c    = Weights1[W1_IW'(int'(cls_q) * int'(HIDDEN_CNT)) +: HIDDEN_CNT];
      cls_score_c = '0;
      for (int h = 0; h < HIDDEN_CNT; h++) begin
         m = hid_q[h] ~^ w1_row_c[h];
         cls_score_c = cls_score_c + SCORE_W'(m);
      end
      better_c = (cls_q == '0) || (cls_score_c > best_score_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_nxt;
   end

   // Datapath and registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         prediction   <= '0;
         score        <= '0;
         feat_q       <= '0;
         hid_q        <= '0;
         grp_q        <= '0;
         cls_q        <= '0;
         best_idx_q   <= '0;
         best_score_q <= '0;
      end else begin
         in_ready  <= (state_nxt == S_IDLE);
         out_valid <= (state_nxt == S_OUT);
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  feat_q <= features;
                  grp_q  <= '0;
               end
            end
            S_HID: begin
               for (int l = 0; l < PAR; l++) begin
                  if (lane_ok_c[l]) hid_q[lane_idx_c[l]] <= lane_hid_c[l];
               end
               grp_q <= grp_q + GRP_W'(1);
               cls_q <= '0;
            end
            S_CLS: begin
               if (better_c) begin
                  best_idx_q   <= PRED_W'(cls_q);
                  best_score_q <= cls_score_c;
               end
               if (cls_q == CLS_W'(CLASS_CNT - 1)) begin
                  prediction <= better_c ? PRED_W'(cls_q) : best_idx_q;
                  score      <= better_c ? cls_score_c : best_score_q;
               end
               cls_q <= cls_q + CLS_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_seq_stream.sv
// Bench for bnn_seq_stream: several parameterisations driven with directed and random
// vectors, each result compared to an arithmetic reference model.
module tb_bnn_seq_stream;

   function automatic logic [479:0] prng(input int unsigned seed);
      logic [479:0] r;
      int unsigned  x;
      r = '0;
      x = seed;
      for (int i = 0; i < 480; i++) begin
         x ^= x << 13;
         x ^= x >> 17;
         x ^= x << 5;
         r[i] = x[11];
      end
      return r;
   endfunction

   localparam logic [479:0] WR0    = prng(32'h1234_5677);
   localparam logic [479:0] WR1F   = prng(32'h0BAD_F00D);
   localparam logic [239:0] WR1    = WR1F[239:0];
   localparam logic [479:0] W0_ONE = {480{1'b1}};
   localparam logic [239:0] W1_C3  = {80'd0, {40{1'b1}}, 120'd0};
   localparam logic [239:0] W1_ZER = '0;
   localparam int LAT_P8  = 5 + 6;
   localparam int LAT_P1  = 40 + 6;
   localparam int LAT_P16 = 3 + 6;
   localparam int LAT_P40 = 1 + 6;

   logic        clk;
   logic        rst;
   logic [47:0] features;
   logic [5:0]  iv, ir, ov, ordy;
   logic [2:0]  pred [6];
   logic [5:0]  scr  [6];

   int n_assert = 0;
   int n_fail   = 0;

   bnn_seq_stream #(.PAR(8),  .Weights0(WR0), .Weights1(WR1)) dut_p8 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .features(features),
      .out_valid(ov[0]), .out_ready(ordy[0]), .prediction(pred[0]), .score(scr[0]));
   bnn_seq_stream #(.PAR(1),  .Weights0(WR0), .Weights1(WR1)) dut_p1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .features(features),
      .out_valid(ov[1]), .out_ready(ordy[1]), .prediction(pred[1]), .score(scr[1]));
   bnn_seq_stream #(.PAR(16), .Weights0(WR0), .Weights1(WR1)) dut_p16 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .features(features),
      .out_valid(ov[2]), .out_ready(ordy[2]), .prediction(pred[2]), .score(scr[2]));
   bnn_seq_stream #(.PAR(40), .Weights0(WR0), .Weights1(WR1)) dut_p40 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .features(features),
      .out_valid(ov[3]), .out_ready(ordy[3]), .prediction(pred[3]), .score(scr[3]));
   bnn_seq_stream #(.PAR(8),  .Weights0(W0_ONE), .Weights1(W1_C3)) dut_c3 (
      .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .features(features),
      .out_valid(ov[4]), .out_ready(ordy[4]), .prediction(pred[4]), .score(scr[4]));
   bnn_seq_stream #(.PAR(8),  .Weights0(W0_ONE), .Weights1(W1_ZER)) dut_z (
      .clk(clk), .rst(rst), .in_valid(iv[5]), .in_ready(ir[5]), .features(features),
      .out_valid(ov[5]), .out_ready(ordy[5]), .prediction(pred[5]), .score(scr[5]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: signed feature sums, sign neurons, XNOR-match counts, first maximum wins
   function automatic void model(input logic [47:0] fv, input logic [479:0] w0,
                                 input logic [239:0] w1, output int p, output int s);
      int hid [40];
      int acc, sc, best;
      for (int h = 0; h < 40; h++) begin
         acc = 0;
         for (int f = 0; f < 12; f++)
            acc += w0[h*12+f] ? int'(fv[f*4 +: 4]) : -int'(fv[f*4 +: 4]);
         hid[h] = (acc >= 0) ? 1 : 0;
      end
      best = -1;
      p = 0;
      for (int c = 0; c < 6; c++) begin
         sc = 0;
         for (int h = 0; h < 40; h++)
            if (hid[h] == int'(w1[c*40+h])) sc++;
         if (sc > best) begin
            best = sc;
            p = c;
         end
      end
      s = best;
   endfunction

   function automatic logic [47:0] rnd48();
      return 48'({$urandom(), $urandom()});
   endfunction

   // Accept one vector on instance k and check latency and result against the model
   task automatic infer(input int k, input logic [47:0] fv, input int lat,
                        input logic [479:0] w0, input logic [239:0] w1,
                        output int p, output int s);
      int n;
      @(negedge clk);
      n = 0;
      while (!ir[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", 32'(ir[k]), 32'd1);
      features = fv;
      iv[k] = 1'b1;
      @(posedge clk);
      #1;
      iv[k] = 1'b0;
      features = rnd48();
      n = 0;
      while (!ov[k] && n < lat + 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      model(fv, w0, w1, p, s);
      chk("latency", 32'(n), 32'(lat));
      chk("prediction", 32'(pred[k]), 32'(p));
      chk("score", 32'(scr[k]), 32'(s));
   endtask

   initial begin
      int p, s;
      logic [47:0] fv;
      rst = 1'b1;
      iv = '0;
      ordy = '1;
      features = '0;
      #2 rst = 1'b0;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk("reset_out_valid", 32'(ov[k]), 32'd0);
         chk("reset_in_ready", 32'(ir[k]), 32'd1);
         chk("reset_prediction", 32'(pred[k]), 32'd0);
         chk("reset_score", 32'(scr[k]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;

      infer(4, 48'd0, LAT_P8, W0_ONE, W1_C3, p, s);
      chk("class3_prediction", 32'(pred[4]), 32'd3);
      chk("class3_score", 32'(scr[4]), 32'd40);

      infer(5, {48{1'b1}}, LAT_P8, W0_ONE, W1_ZER, p, s);
      chk("tie_prediction", 32'(pred[5]), 32'd0);
      chk("tie_score", 32'(scr[5]), 32'd0);

      for (int i = 0; i < 200; i++) begin
         fv = rnd48();
         infer(0, fv, LAT_P8,  WR0, WR1, p, s);
         infer(1, fv, LAT_P1,  WR0, WR1, p, s);
         infer(2, fv, LAT_P16, WR0, WR1, p, s);
         infer(3, fv, LAT_P40, WR0, WR1, p, s);
      end

      // Backpressure: result must hold while out_ready is low
      ordy[0] = 1'b0;
      infer(0, rnd48(), LAT_P8, WR0, WR1, p, s);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         iv[0] = i[0];
         features = rnd48();
         @(posedge clk);
         #1;
         chk("hold_out_valid", 32'(ov[0]), 32'd1);
         chk("hold_prediction", 32'(pred[0]), 32'(p));
         chk("hold_score", 32'(scr[0]), 32'(s));
         chk("hold_in_ready", 32'(ir[0]), 32'd0);
      end
      @(negedge clk);
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out_valid", 32'(ov[0]), 32'd0);
      chk("release_in_ready", 32'(ir[0]), 32'd1);

      // Reset in the middle of the class phase
      @(negedge clk);
      features = rnd48();
      iv[0] = 1'b1;
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      repeat (5 + 2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midreset_out_valid", 32'(ov[0]), 32'd0);
      chk("midreset_prediction", 32'(pred[0]), 32'd0);
      chk("midreset_score", 32'(scr[0]), 32'd0);
      chk("midreset_in_ready", 32'(ir[0]), 32'd1);
      chk("midreset_c3_prediction", 32'(pred[4]), 32'd0);
      chk("midreset_c3_score", 32'(scr[4]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      infer(0, rnd48(), LAT_P8, WR0, WR1, p, s);

      for (int i = 0; i < 100; i++)
         infer(0, rnd48(), LAT_P8, WR0, WR1, p, s);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
